// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory / I/O block: address map,
// UART transmitter states and the decoded device select.
package dmem_io_pkg;

  // Byte addresses of the memory-mapped I/O registers.
  localparam logic [31:0] LED_ADDR         = 32'h0000_7F00;
  localparam logic [31:0] TIMER_ADDR       = 32'h0000_7F04;
  localparam logic [31:0] UART_TXDATA_ADDR = 32'h0000_7F10;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h0000_7F14;

  // Serial transmitter states; anything other than idle means a frame is in flight.
  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // Result of address decode: which target the current access hits.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_TIMER,
    SEL_TXDATA,
    SEL_STATUS
  } dev_sel_e;

  // Word index of a byte address; the two byte-lane bits are dropped because
  // every access is a full word.
  function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/dmem_io_uart_tx_fsm.sv
// 8N1 serial transmitter: start bit, eight data bits LSB first, one stop bit,
// each bit held for CLKS_PER_BIT clocks. The line idles high.
module uart_tx_fsm
  import dmem_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              baud_done;

  // The last clock of the current bit period.
  assign baud_done = (baud_q == BAUD_LAST);

  // Frame sequencer with the line driven from a register so it never glitches.
  // NOTE: every state register here uses <= so all of them update together
  // from the values seen before the edge; = would make order of statements matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        UART_IDLE: begin
          if (start) begin
            state_q <= UART_START;
            shift_q <= data;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= UART_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            // Three-bit counter wraps 7 -> 0 as the last data bit finishes.
            bit_q  <= bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              state_q <= UART_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        UART_STOP: begin
          // A start request in the final stop clock is not seen: the FSM is
          // still busy here and only reaches idle on this same edge.
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= UART_IDLE;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= UART_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign busy = (state_q != UART_IDLE);
  assign tx   = tx_q;

endmodule

// File: rtl/dmem_io.sv
// CPU data-side memory and I/O: word RAM, LED register, free-running timer
// and a UART transmitter, all decoded from the CPU byte address.
module dmem_io
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        uart_tx
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [31:0]   word_addr;
  logic [AW-1:0] ram_idx;
  dev_sel_e      sel;

  logic [31:0]   mem_q [RAM_WORDS];
  logic          ram_we;

  logic [15:0]   led_q,    led_d;
  logic [31:0]   timer_q,  timer_d;
  logic [7:0]    txdata_q, txdata_d;

  logic          uart_start;
  logic          uart_busy;

  assign word_addr = word_of(addr);
  assign ram_idx   = word_addr[AW-1:0];

  // Address decode on the word index; RAM occupies the bottom of the map.
  // NOTE: sel gets a value before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    sel = SEL_NONE;
    if (word_addr < 32'(RAM_WORDS))                    sel = SEL_RAM;
    else if (word_addr == word_of(LED_ADDR))           sel = SEL_LED;
    else if (word_addr == word_of(TIMER_ADDR))         sel = SEL_TIMER;
    else if (word_addr == word_of(UART_TXDATA_ADDR))   sel = SEL_TXDATA;
    else if (word_addr == word_of(UART_STATUS_ADDR))   sel = SEL_STATUS;
  end

  assign ram_we     = mem_write && (sel == SEL_RAM) && !rst;
  assign uart_start = mem_write && (sel == SEL_TXDATA);

  // RAM write port; a read in the same cycle still sees the old word.
  // NOTE: the array has no reset branch on purpose -- its contents survive
  // rst and it maps onto plain block/distributed RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_idx] <= wdata;
  end

  // Next-state for the I/O registers; a timer write wins over the increment.
  always_comb begin
    led_d    = led_q;
    timer_d  = timer_q + 32'd1;
    txdata_d = txdata_q;
    if (mem_write) begin
      case (sel)
        SEL_LED:    led_d   = wdata[15:0];
        SEL_TIMER:  timer_d = wdata;
        SEL_TXDATA: if (!uart_busy) txdata_d = wdata[7:0];
        default:    ;
      endcase
    end
  end

  // I/O registers; reset beats any write presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= '0;
      timer_q  <= '0;
      txdata_q <= '0;
    end else begin
      led_q    <= led_d;
      timer_q  <= timer_d;
      txdata_q <= txdata_d;
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_RAM:    rdata = mem_q[ram_idx];
      SEL_LED:    rdata = {16'b0, led_q};
      SEL_TIMER:  rdata = timer_q;
      SEL_TXDATA: rdata = {24'b0, txdata_q};
      SEL_STATUS: rdata = {31'b0, uart_busy};
      default:    rdata = '0;
    endcase
  end

  uart_tx_fsm #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start),
    .data (wdata[7:0]),
    .busy (uart_busy),
    .tx   (uart_tx)
  );

  assign led = led_q;

endmodule
